serv_dbus_ram: RTL and testbench

- Wishbone-classic responder (target) for the SERV data bus. It is the memory-side end of the load/store path whose initiator side drives address, write data and byte selects from the CPU's data buffer register.
- Accepts one word-aligned request at a time, applies byte-lane writes or returns a full 32-bit read word, and acknowledges with a single-cycle ack after a configurable number of wait states.
- Sits between the SERV data-bus arbiter output and on-chip SRAM.

---
 rtl/serv_dbus_ram_if.sv | 13 +
 rtl/serv_dbus_ram.sv | 157 +++++++++++++++
 tb/tb_serv_dbus_ram.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_dbus_ram_if.sv
// Wishbone-classic data-bus bundle between the SERV load/store initiator and the RAM responder.
interface serv_dbus_ram_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/serv_dbus_ram.sv
// Single-port SRAM responder for the SERV data bus: one word-aligned request at a time,
// byte-lane writes, full-word reads, single-cycle ack after WAIT_STATES extra cycles.
module serv_dbus_ram #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0,
    parameter     MEMFILE     = ""
) (
    input  logic             i_clk,
    input  logic             i_rst,
    serv_dbus_ram_if.slave   wb,
    output logic             o_busy
);

    localparam int         DEPTH = 2 ** AW;
    localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_next;
    logic          w_accept;
    logic          w_commit;

    logic [AW-1:0] r_adr;
    logic [31:0]   r_dat;
    logic [3:0]    r_sel;
    logic          r_we;

    logic [AW-1:0] w_adr;
    logic [31:0]   w_dat;
    logic [3:0]    w_sel;
    logic          w_we;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rdt;
    logic          r_ack;
    logic          r_busy;
    logic          w_unused;

    // Byte offset and bits above the memory size are ignored, so high addresses alias.
    assign w_unused = ^{wb.adr[31:AW+2], wb.adr[1:0]};

    // Next-state logic: ACK always returns to IDLE, so a cyc still high in ACK is never re-accepted.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wb.cyc) begin
                    w_accept   = 1'b1;
                    w_cnt_next = LP_WS;
                    if (LP_WS == 4'd0) begin
                        w_state_next = S_ACK;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!wb.cyc) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_next = S_ACK;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Request source: zero-wait accesses commit on the acceptance edge, before the latch is loaded.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_adr = wb.adr[AW+1:2];
            w_dat = wb.dat;
            w_sel = wb.sel;
            w_we  = wb.we;
        end else begin
            w_adr = r_adr;
            w_dat = r_dat;
            w_sel = r_sel;
            w_we  = r_we;
        end
    end

    assign w_commit = (w_state_next == S_ACK) && !i_rst;

    // State, counter and registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdt   <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= (w_state_next == S_ACK);
            r_busy  <= (w_state_next != S_IDLE);
            if (w_commit && !w_we) begin
                r_rdt <= r_mem[w_adr];
            end
        end
    end

    // Request latch, loaded only on acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_adr <= '0;
            r_dat <= 32'h0000_0000;
            r_sel <= 4'h0;
            r_we  <= 1'b0;
        end else if (w_accept) begin
            r_adr <= wb.adr[AW+1:2];
            r_dat <= wb.dat;
            r_sel <= wb.sel;
            r_we  <= wb.we;
        end
    end

    // Memory array: never reset; only enabled byte lanes are written on the commit edge.
    always_ff @(posedge i_clk) begin
        if (w_commit && w_we) begin
            for (int n = 0; n < 4; n++) begin
                if (w_sel[n]) begin
                    r_mem[w_adr][8*n +: 8] <= w_dat[8*n +: 8];
                end
            end
        end
    end

    assign wb.rdt = r_rdt;
    assign wb.ack = r_ack;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_serv_dbus_ram.sv
// Bench for serv_dbus_ram: one instance with 0 and one with 3 wait states, checked every
// cycle against a transaction-level latency/memory model plus literal expectations.
module tb_serv_dbus_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic [31:0] d_adr [2];
    logic [31:0] d_dat [2];
    logic [3:0]  d_sel [2];
    logic        d_we  [2];
    logic        d_cyc [2];

    logic [31:0] q_rdt  [2];
    logic        q_ack  [2];
    logic        q_busy [2];
    logic        busy0, busy1;

    serv_dbus_ram_if if0();
    serv_dbus_ram_if if1();

    assign if0.adr = d_adr[0];
    assign if0.dat = d_dat[0];
    assign if0.sel = d_sel[0];
    assign if0.we  = d_we[0];
    assign if0.cyc = d_cyc[0];
    assign if1.adr = d_adr[1];
    assign if1.dat = d_dat[1];
    assign if1.sel = d_sel[1];
    assign if1.we  = d_we[1];
    assign if1.cyc = d_cyc[1];

    assign q_rdt[0]  = if0.rdt;
    assign q_ack[0]  = if0.ack;
    assign q_busy[0] = busy0;
    assign q_rdt[1]  = if1.rdt;
    assign q_ack[1]  = if1.ack;
    assign q_busy[1] = busy1;

    serv_dbus_ram #(.AW(10), .WAIT_STATES(0), .MEMFILE("")) u_ws0 (
        .i_clk (clk),
        .i_rst (rst[0]),
        .wb    (if0),
        .o_busy(busy0)
    );

    serv_dbus_ram #(.AW(10), .WAIT_STATES(3), .MEMFILE("")) u_ws3 (
        .i_clk (clk),
        .i_rst (rst[1]),
        .wb    (if1),
        .o_busy(busy1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_no = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_no);
        end
    endtask

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    // Transaction-level model: a request accepted in cycle k commits at the end of cycle k+WS,
    // unless cyc falls or reset hits first; the ack cycle itself never accepts.
    bit          m_pend [2];
    int          m_acc  [2];
    logic        m_ack  [2];
    logic        m_busy [2];
    logic [31:0] m_rdt  [2];
    logic [31:0] m_adr  [2];
    logic [31:0] m_dat  [2];
    logic [3:0]  m_sel  [2];
    logic        m_we   [2];
    logic [31:0] mm     [2][1024];

    task automatic model_step(input int i);
        bit commit;
        int w;
        commit = 1'b0;
        if (rst[i]) begin
            m_pend[i] = 1'b0;
            m_ack[i]  = 1'b0;
            m_busy[i] = 1'b0;
            m_rdt[i]  = 32'h0;
        end else begin
            if (m_pend[i]) begin
                if (!d_cyc[i]) begin
                    m_pend[i] = 1'b0;
                end else if (cyc_no == m_acc[i] + ws_of(i)) begin
                    commit    = 1'b1;
                    m_pend[i] = 1'b0;
                end
            end else if (d_cyc[i] && !m_ack[i]) begin
                m_adr[i] = d_adr[i];
                m_dat[i] = d_dat[i];
                m_sel[i] = d_sel[i];
                m_we[i]  = d_we[i];
                m_acc[i] = cyc_no;
                if (ws_of(i) == 0) commit = 1'b1;
                else m_pend[i] = 1'b1;
            end
            if (commit) begin
                w = int'((m_adr[i] / 32'd4) % 32'd1024);
                if (m_we[i]) begin
                    for (int n = 0; n < 4; n++)
                        if (m_sel[i][n]) mm[i][w][8*n +: 8] = m_dat[i][8*n +: 8];
                end else begin
                    m_rdt[i] = mm[i][w];
                end
            end
            m_ack[i]  = commit;
            m_busy[i] = m_pend[i] || commit;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        cyc_no++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("ack%0d", i),  {31'b0, q_ack[i]},  {31'b0, m_ack[i]});
                chk($sformatf("busy%0d", i), {31'b0, q_busy[i]}, {31'b0, m_busy[i]});
                chk($sformatf("rdt%0d", i),  q_rdt[i], m_rdt[i]);
            end
        end
    end

    // Raise a request at a negedge and wait (bounded) for ack; cyc is held through the ack
    // cycle and, if drop is set, released at the next negedge (the responder's IDLE cycle).
    task automatic xfer(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input bit drop,
                        output logic [31:0] rd, output int lat, output int ack_t);
        d_adr[i] = a;
        d_dat[i] = d;
        d_sel[i] = s;
        d_we[i]  = w;
        d_cyc[i] = 1'b1;
        lat   = 0;
        rd    = 32'h0;
        ack_t = -1;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (q_ack[i] === 1'b1) begin
                rd    = q_rdt[i];
                ack_t = cyc_no;
                break;
            end
        end
        if (ack_t < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout%0d: got no ack expected ack within 40 cycles (adr %h)", i, a);
        end
        @(negedge clk);
        if (drop) d_cyc[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat, t1, t2, t3;
        for (int i = 0; i < 2; i++) begin
            rst[i]   = 1'b1;
            d_adr[i] = 32'h0;
            d_dat[i] = 32'h0;
            d_sel[i] = 4'h0;
            d_we[i]  = 1'b0;
            d_cyc[i] = 1'b0;
        end
        idle(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_en = 1'b1;
        chk("rst_rdt0", q_rdt[0], 32'h0);
        chk("rst_busy1", {31'b0, q_busy[1]}, 32'h0);
        idle(1);

        // ---- zero wait states ----
        xfer(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, rd, lat, t1);
        chk("ws0_wr_lat", lat, 32'd1);
        idle(1);
        xfer(0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t1);
        chk("ws0_rd10", rd, 32'hDEAD_BEEF);
        chk("ws0_rd_lat", lat, 32'd1);
        idle(1);
        xfer(0, 32'h0000_0014, 32'h1122_3344, 4'hF, 1'b1, 1'b1, rd, lat, t1);
        idle(1);
        xfer(0, 32'h0000_0014, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b1, rd, lat, t1);
        idle(1);
        xfer(0, 32'h0000_0014, 32'h0, 4'h0, 1'b0, 1'b1, rd, lat, t1);
        chk("ws0_lanes", rd, 32'h11BB_33DD);
        idle(1);
        xfer(0, 32'h0000_0014, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1, rd, lat, t1);
        chk("ws0_sel0_lat", lat, 32'd1);
        idle(1);
        xfer(0, 32'h0000_0014, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t1);
        chk("ws0_sel0_keep", rd, 32'h11BB_33DD);
        idle(1);
        xfer(0, 32'h0000_1004, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b1, rd, lat, t1);
        idle(1);
        xfer(0, 32'h0000_0004, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t1);
        chk("ws0_alias", rd, 32'h5A5A_5A5A);
        idle(1);
        // back-to-back: cyc stays high and the next request appears in the IDLE cycle
        xfer(0, 32'h0000_0020, 32'h0102_0304, 4'hF, 1'b1, 1'b0, rd, lat, t1);
        xfer(0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, t2);
        chk("ws0_b2b_rd", rd, 32'h0102_0304);
        chk("ws0_b2b_gap1", t2 - t1, 32'd2);
        xfer(0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t3);
        chk("ws0_b2b_gap2", t3 - t2, 32'd2);
        chk("ws0_b2b_rd2", rd, 32'hDEAD_BEEF);
        idle(1);
        // write presented together with reset is ignored
        d_adr[0] = 32'h0000_0010;
        d_dat[0] = 32'h0;
        d_sel[0] = 4'hF;
        d_we[0]  = 1'b1;
        d_cyc[0] = 1'b1;
        rst[0]   = 1'b1;
        idle(1);
        rst[0]   = 1'b0;
        d_cyc[0] = 1'b0;
        idle(2);
        chk("ws0_rst_rdt", q_rdt[0], 32'h0);
        xfer(0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t1);
        chk("ws0_rst_keep", rd, 32'hDEAD_BEEF);
        idle(2);

        // ---- three wait states ----
        xfer(1, 32'h0000_0008, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b1, rd, lat, t1);
        chk("ws3_wr_lat", lat, 32'd4);
        idle(1);
        xfer(1, 32'h0000_0018, 32'h1818_1818, 4'hF, 1'b1, 1'b1, rd, lat, t1);
        idle(1);
        xfer(1, 32'h0000_000C, 32'hCAFE_BABE, 4'hF, 1'b1, 1'b1, rd, lat, t1);
        idle(1);
        xfer(1, 32'h0000_000C, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t1);
        chk("ws3_rd_lat", lat, 32'd4);
        chk("ws3_rd0c", rd, 32'hCAFE_BABE);
        idle(1);
        // abort after one WAIT cycle
        d_adr[1] = 32'h0000_0018;
        d_dat[1] = 32'hFFFF_FFFF;
        d_sel[1] = 4'hF;
        d_we[1]  = 1'b1;
        d_cyc[1] = 1'b1;
        idle(1);
        d_cyc[1] = 1'b0;
        idle(6);
        chk("ws3_abort_rdt", q_rdt[1], 32'hCAFE_BABE);
        xfer(1, 32'h0000_0018, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t1);
        chk("ws3_abort_keep", rd, 32'h1818_1818);
        idle(1);
        // reset during the first WAIT cycle of a write
        d_adr[1] = 32'h0000_0008;
        d_dat[1] = 32'h0;
        d_sel[1] = 4'hF;
        d_we[1]  = 1'b1;
        d_cyc[1] = 1'b1;
        idle(1);
        rst[1] = 1'b1;
        idle(1);
        rst[1]   = 1'b0;
        d_cyc[1] = 1'b0;
        idle(2);
        chk("ws3_rst_rdt", q_rdt[1], 32'h0);
        xfer(1, 32'h0000_0008, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t1);
        chk("ws3_rst_keep8", rd, 32'h0BAD_F00D);
        idle(1);
        xfer(1, 32'h0000_000C, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t1);
        chk("ws3_rst_keep0c", rd, 32'hCAFE_BABE);
        idle(1);
        // reset landing on the commit edge of a write
        d_adr[1] = 32'h0000_0008;
        d_dat[1] = 32'h0;
        d_sel[1] = 4'hF;
        d_we[1]  = 1'b1;
        d_cyc[1] = 1'b1;
        idle(3);
        rst[1] = 1'b1;
        idle(1);
        rst[1]   = 1'b0;
        d_cyc[1] = 1'b0;
        idle(2);
        xfer(1, 32'h0000_0008, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t1);
        chk("ws3_commit_rst", rd, 32'h0BAD_F00D);
        idle(1);
        // back-to-back with wait states
        xfer(1, 32'h0000_001C, 32'h1C1C_1C1C, 4'hF, 1'b1, 1'b0, rd, lat, t1);
        xfer(1, 32'h0000_001C, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, t2);
        chk("ws3_b2b_rd", rd, 32'h1C1C_1C1C);
        chk("ws3_b2b_gap1", t2 - t1, 32'd5);
        xfer(1, 32'h0000_0018, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat, t3);
        chk("ws3_b2b_gap2", t3 - t2, 32'd5);
        chk("ws3_b2b_rd2", rd, 32'h1818_1818);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
